// File: rtl/seg7_scan_display.sv
// Multiplexed hex 7-segment driver: scans DIGITS digits with a dead-time gap between slots.
// New data is committed only at frame boundaries, so a frame never shows a mix of old and new data.
module seg7_scan_display #(
    parameter int DIGITS          = 2,
    parameter int DIV_BITS        = 6,
    parameter int BLANK_CYCLES    = 2,
    parameter int SEG_ACTIVE_HIGH = 1,
    parameter int DIG_ACTIVE_HIGH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  blank_lz,
    input  logic                  en,
    output logic [6:0]            seg,
    output logic                  seg_dp,
    output logic [DIGITS-1:0]     dig_en,
    output logic                  frame_done
);
    localparam int                DW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIV_BITS-1:0] P_LAST  = '1;
    localparam logic [DIV_BITS-1:0] P_BLANK = DIV_BITS'(BLANK_CYCLES);
    localparam logic [DW-1:0]     D_LAST  = DW'(DIGITS - 1);
    localparam logic              SEG_INV = (SEG_ACTIVE_HIGH == 0);
    localparam logic [6:0]        SEG_OFF = {7{SEG_INV}};
    localparam logic [DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_HIGH != 0) ? '0 : '1;

    logic [DIV_BITS-1:0]     p_q, p_d;
    logic [DW-1:0]           d_q, d_d;
    logic [DIGITS-1:0][3:0]  disp_q, disp_d, shad_q, shad_d;
    logic [DIGITS-1:0]       dpd_q, dpd_d, shdp_q, shdp_d;
    logic                    pend_q, pend_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [DIGITS-1:0]       dig_q, dig_d;
    logic                    fd_q, fd_d;

    logic                    boundary;
    logic [3:0]              nib;
    logic                    dpb, zabove, supp;
    logic [6:0]              lit;
    logic [DIGITS-1:0]       onehot;

    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0: font = 7'b1111110;  4'h1: font = 7'b0110000;
            4'h2: font = 7'b1101101;  4'h3: font = 7'b1111001;
            4'h4: font = 7'b0110011;  4'h5: font = 7'b1011011;
            4'h6: font = 7'b1011111;  4'h7: font = 7'b1110000;
            4'h8: font = 7'b1111111;  4'h9: font = 7'b1111011;
            4'hA: font = 7'b1110111;  4'hB: font = 7'b0011111;
            4'hC: font = 7'b1001110;  4'hD: font = 7'b0111101;
            4'hE: font = 7'b1001111;  default: font = 7'b1000111;
        endcase
    endfunction

    always_comb begin
        boundary = en && (p_q == P_LAST) && (d_q == D_LAST);

        p_d = p_q + 1'b1;
        d_d = d_q;
        if (!en) begin
            p_d = '0;
            d_d = '0;
        end else if (p_q == P_LAST) begin
            d_d = (d_q == D_LAST) ? '0 : d_q + 1'b1;
        end

        shad_d = shad_q;
        shdp_d = shdp_q;
        if (load) begin
            shad_d = value;
            shdp_d = dp_in;
        end

        // A load on the boundary cycle bypasses the shadow so it is not delayed a whole frame.
        disp_d = disp_q;
        dpd_d  = dpd_q;
        pend_d = pend_q;
        if (boundary) begin
            pend_d = 1'b0;
            if (load) begin
                disp_d = value;
                dpd_d  = dp_in;
            end else if (pend_q) begin
                disp_d = shad_q;
                dpd_d  = shdp_q;
            end
        end else if (load) begin
            pend_d = 1'b1;
        end

        nib    = '0;
        dpb    = 1'b0;
        zabove = 1'b1;
        supp   = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zabove = zabove & (disp_q[i] == 4'd0);
            if (int'(d_q) == i) begin
                nib  = disp_q[i];
                dpb  = dpd_q[i];
                supp = blank_lz && zabove && (i != 0);
            end
        end
        lit    = supp ? 7'h00 : font(nib);
        onehot = DIGITS'(1) << d_q;

        seg_d = en ? (lit ^ SEG_OFF) : SEG_OFF;
        dp_d  = en ? (dpb ^ SEG_INV) : SEG_INV;
        dig_d = DIG_OFF;
        if (en && (p_q >= P_BLANK))
            dig_d = DIG_OFF ^ onehot;
        fd_d  = boundary;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q    <= '0;
            d_q    <= '0;
            disp_q <= '0;
            dpd_q  <= '0;
            shad_q <= '0;
            shdp_q <= '0;
            pend_q <= 1'b0;
            seg_q  <= SEG_OFF;
            dp_q   <= SEG_INV;
            dig_q  <= DIG_OFF;
            fd_q   <= 1'b0;
        end else begin
            p_q    <= p_d;
            d_q    <= d_d;
            disp_q <= disp_d;
            dpd_q  <= dpd_d;
            shad_q <= shad_d;
            shdp_q <= shdp_d;
            pend_q <= pend_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            dig_q  <= dig_d;
            fd_q   <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign seg_dp     = dp_q;
    assign dig_en     = dig_q;
    assign frame_done = fd_q;
endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Parametrised multiplexed 7-segment display driver. Successor to the fixed two-digit, counter-bit-driven scan in the board top level.
- Drives DIGITS hex digits with a configurable scan rate and a dead-time guard between digits. Supports per-digit decimal points, leading-zero blanking, selectable output polarity, and tear-free updates at frame boundaries.
- Sits between the core's debug/status outputs and board pins.

Parameters:
- DIGITS, 2, number of digits scanned (1..8).
- DIV_BITS, 6, log2 of slot length; each digit slot lasts S = 2^DIV_BITS clocks.
- BLANK_CYCLES, 2, clocks at the start of each slot with all digit enables inactive (1..S-1).
- SEG_ACTIVE_HIGH, 1, 1 = segment/dp lit when high; 0 = lit when low.
- DIG_ACTIVE_HIGH, 1, 1 = digit enable active high; 0 = active low.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- value  in  4*DIGITS  hex nibbles; nibble i = digit i (digit 0 = least significant).
- dp_in  in  DIGITS  decimal point per digit.
- load  in  1  one-cycle strobe; captures value/dp_in.
- blank_lz  in  1  enable leading-zero blanking.
- en  in  1  scan enable.
- seg  out  7  segments {a,b,c,d,e,f,g}, polarity per SEG_ACTIVE_HIGH.
- seg_dp  out  1  decimal point, same polarity.
- dig_en  out  DIGITS  digit enables, polarity per DIG_ACTIVE_HIGH.
- frame_done  out  1  one-cycle pulse at the end of the last digit slot.

Behaviour:
Reset (async, rst_n=0):
- slot counter p=0, digit index d=0.
- display and shadow registers = 0; pending=0; frame_done=0.
- seg, seg_dp and dig_en all at their inactive levels.

Scan:
- While en=1, p counts 0..S-1 and wraps.
- At the wrap, d increments, going from DIGITS-1 back to 0.
- Every output is registered: it reflects (p,d) of the previous cycle.

Digit enables:
- dig_en[d] is active when p >= BLANK_CYCLES.
- All digit enables are inactive when p < BLANK_CYCLES.
- At most one digit enable is ever active.
- Per slot: S-BLANK_CYCLES active clocks, then a BLANK_CYCLES dead gap before the next digit.

Segments:
- seg and seg_dp change only while all enables are inactive.
- seg = hex font of display nibble d:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
  - the listed codes are lit-high patterns; invert all of them when SEG_ACTIVE_HIGH=0.
- seg_dp = display dp bit d.

Leading-zero blanking:
- When blank_lz=1, digit i is suppressed if it and all digits above it are zero.
- Suppressed means segments are driven inactive; the digit enable still cycles normally.
- Digit 0 is never suppressed.
- dp is not affected by blanking.

Load and commit:
- load=1 captures value/dp_in into the shadow registers and sets pending.
- If several loads arrive before a commit, the last one wins.

Frame boundary:
- The boundary is the cycle where p=S-1 and d=DIGITS-1.
- On that cycle frame_done pulses the following cycle.
- Commit rule at the boundary:
  - if load is high on the boundary cycle, display takes value/dp_in directly;
  - else if pending=1, display takes the shadow registers;
  - pending clears in either case.
- The displayed frame therefore never mixes old and new data.

Disable (en=0):
- The next output cycle drives dig_en, seg and seg_dp inactive.
- p and d reset to 0; frame_done stays 0.
- load still captures into the shadow registers; the commit happens only at a frame boundary.
- When en rises, the scan restarts at digit 0, p=0, with a full blank window.

Reset mid-frame:
- Outputs go inactive immediately (asynchronously), and all state clears.
- Any pending data is lost.

Test Plan:
Common setup: DIGITS=2, DIV_BITS=3 (S=8), BLANK_CYCLES=2, both polarities active-high unless stated.
1. Reset: hold rst_n=0, en=1. Expect seg=0, seg_dp=0, dig_en=00, frame_done=0. After release, the first 2 cycles have dig_en=00.
2. Basic scan: load value=8'h3A, dp_in=2'b01, wait one frame. Expect:
   - digit 0: dig_en=01 for 6 clocks with seg=1110111, seg_dp=1;
   - 2 clocks at 00;
   - digit 1: dig_en=10 for 6 clocks with seg=1111001, seg_dp=0;
   - frame_done pulses once every 16 clocks.
3. Tear-free update: with 8'h3A displayed, load 8'h12 during digit 0's slot. Expect digit 1 still shows 3 this frame; the next frame shows 2 on digit 0 and 1 on digit 1.
4. Leading-zero blanking: blank_lz=1.
   - value 8'h05: digit 1 seg=0000000, digit 0 seg=1011011.
   - value 8'h00: digit 0 shows 1111110.
   - value 8'h50: both digits shown.
5. Enable gating: drop en at p=4 of digit 1. Expect dig_en=00 the next cycle. Re-enable and expect 2 blank cycles, then dig_en=01.
6. Polarity: SEG_ACTIVE_HIGH=0, DIG_ACTIVE_HIGH=0, display 8'h88. Expect seg=0000000 when lit, dig_en idle 11, active digit 10/01. Reset drives seg=1111111, seg_dp=1, dig_en=11.
